// File: rtl/alu4b_pkg.sv
// Shared definitions for the 4-bit ALU issuer: opcode constants and the queued request format.
package alu4b_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_NOT_A  = 4'b0001;
  localparam logic [3:0] OP_NAND   = 4'b0010;
  localparam logic [3:0] OP_AND    = 4'b0011;
  localparam logic [3:0] OP_SUB_BA = 4'b0101;
  localparam logic [3:0] OP_SUB_AB = 4'b1001;
  localparam logic [3:0] OP_OR     = 4'b1110;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
  } alu4b_req_t;

endpackage

// File: rtl/alu4b_issue_if.sv
// Request and response valid/ready channels of the ALU issuer.
interface alu4b_issue_if;

  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       req_use_acc;

  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] resp_out;
  logic       resp_negative;
  logic       resp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, req_use_acc, resp_ready,
    input  req_ready, resp_valid, resp_out, resp_negative, resp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_use_acc, resp_ready,
    output req_ready, resp_valid, resp_out, resp_negative, resp_zero
  );

endinterface

// File: rtl/ALU4B.sv
// Combinational 4-bit ALU driven by the issuer; unused opcodes produce zero.
module ALU4B
  import alu4b_pkg::*;
(
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] opCode,
  output logic [3:0] out,
  output logic       negative,
  output logic       zero
);

  always_comb begin
    out = 4'd0;
    case (opCode)
      OP_ADD:    out = in1 + in2;
      OP_NOT_A:  out = ~in1;
      OP_NAND:   out = ~(in1 & in2);
      OP_AND:    out = in1 & in2;
      OP_SUB_BA: out = in2 - in1;
      OP_SUB_AB: out = in1 - in2;
      OP_OR:     out = in1 | in2;
      default:   out = 4'd0;
    endcase
  end

  assign negative = out[3];
  assign zero     = (out == 4'd0);

endmodule

// File: rtl/alu4b_req_fifo.sv
// Small request queue with wrap-around pointers; the head entry is always visible on head.
module alu4b_req_fifo
  import alu4b_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  alu4b_req_t din,
  output alu4b_req_t head,
  output logic [1:0] count
);

  alu4b_req_t mem [DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu4b_issue.sv
// Issues queued requests to the combinational ALU one per cycle and registers results
// into the response channel; the accumulator lets dependent ops run back-to-back.
module alu4b_issue
  import alu4b_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu4b_issue_if.slave     bus,
  output logic [3:0]       alu_op,
  output logic [3:0]       alu_in1,
  output logic [3:0]       alu_in2,
  input  logic [3:0]       alu_out,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic [3:0]       acc
);

  alu4b_req_t wr_req;
  alu4b_req_t head;
  logic [1:0] count;
  logic       empty;
  logic       full;
  logic       push;
  logic       pop;

  assign wr_req.op      = bus.req_op;
  assign wr_req.a       = bus.req_a;
  assign wr_req.b       = bus.req_b;
  assign wr_req.use_acc = bus.req_use_acc;

  // Ready comes from the registered count only, so a full queue refuses even when it pops.
  assign empty         = (count == 2'd0);
  assign full          = (count == 2'(DEPTH));
  assign bus.req_ready = !full;
  assign push          = bus.req_valid && !full;
  assign pop           = !empty && (!bus.resp_valid || bus.resp_ready);

  alu4b_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wr_req),
    .head  (head),
    .count (count)
  );

  always_comb begin
    alu_op  = 4'd0;
    alu_in1 = 4'd0;
    alu_in2 = 4'd0;
    if (!empty) begin
      alu_op  = head.op;
      alu_in1 = head.use_acc ? acc : head.a;
      alu_in2 = head.b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_valid    <= 1'b0;
      bus.resp_out      <= 4'd0;
      bus.resp_negative <= 1'b0;
      bus.resp_zero     <= 1'b0;
      acc               <= 4'd0;
    end else if (pop) begin
      bus.resp_valid    <= 1'b1;
      bus.resp_out      <= alu_out;
      bus.resp_negative <= alu_negative;
      bus.resp_zero     <= alu_zero;
      acc               <= alu_out;
    end else if (bus.resp_valid && bus.resp_ready) begin
      bus.resp_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu4b_issue.sv
// Directed bench for alu4b_issue wired to ALU4B; expected values are hand-computed.
module tb_alu4b_issue;
  import alu4b_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] alu_op;
  logic [3:0] alu_in1;
  logic [3:0] alu_in2;
  logic [3:0] alu_out;
  logic       alu_negative;
  logic       alu_zero;
  logic [3:0] acc;

  int errors = 0;
  int checks = 0;

  alu4b_issue_if bus ();

  alu4b_issue #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .alu_op       (alu_op),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_out      (alu_out),
    .alu_negative (alu_negative),
    .alu_zero     (alu_zero),
    .acc          (acc)
  );

  ALU4B u_alu (
    .in1      (alu_in1),
    .in2      (alu_in2),
    .opCode   (alu_op),
    .out      (alu_out),
    .negative (alu_negative),
    .zero     (alu_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Holds a request until it is accepted at an edge; returns 1ns after that edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] a,
                               input logic [3:0] b, input logic use_acc);
    logic accepted;
    accepted        = 1'b0;
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_a       = a;
    bus.req_b       = b;
    bus.req_use_acc = use_acc;
    for (int i = 0; i < 20 && !accepted; i++) begin
      accepted = bus.req_ready;
      nextCycle();
    end
    bus.req_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 8'd0, 8'd1);
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_op      = 4'd0;
    bus.req_a       = 4'd0;
    bus.req_b       = 4'd0;
    bus.req_use_acc = 1'b0;
    bus.resp_ready  = 1'b1;

    #12;
    checkOutput("rst_resp_valid", 8'(bus.resp_valid), 8'd0);
    checkOutput("rst_acc", 8'(acc), 8'd0);
    checkOutput("rst_req_ready", 8'(bus.req_ready), 8'd1);
    checkOutput("rst_alu_op", 8'(alu_op), 8'd0);
    rst = 1'b0;
    nextCycle();

    $display("[TB] single add");
    applyStimulus(OP_ADD, 4'b0011, 4'b0101, 1'b0);
    checkOutput("add_no_bypass", 8'(bus.resp_valid), 8'd0);
    checkOutput("add_alu_in1", 8'(alu_in1), 8'h3);
    checkOutput("add_alu_in2", 8'(alu_in2), 8'h5);
    nextCycle();
    checkOutput("add_valid", 8'(bus.resp_valid), 8'd1);
    checkOutput("add_out", 8'(bus.resp_out), 8'h8);
    checkOutput("add_neg", 8'(bus.resp_negative), 8'd1);
    checkOutput("add_zero", 8'(bus.resp_zero), 8'd0);
    checkOutput("add_acc", 8'(acc), 8'h8);

    $display("[TB] overflow wrap");
    applyStimulus(OP_ADD, 4'b0001, 4'b1111, 1'b0);
    nextCycle();
    checkOutput("wrap_valid", 8'(bus.resp_valid), 8'd1);
    checkOutput("wrap_out", 8'(bus.resp_out), 8'h0);
    checkOutput("wrap_zero", 8'(bus.resp_zero), 8'd1);
    checkOutput("wrap_neg", 8'(bus.resp_negative), 8'd0);
    nextCycle();
    checkOutput("wrap_taken", 8'(bus.resp_valid), 8'd0);

    $display("[TB] accumulator chain");
    applyStimulus(OP_ADD, 4'b0011, 4'b0001, 1'b0);
    applyStimulus(OP_SUB_BA, 4'b0000, 4'b0000, 1'b1);
    checkOutput("chain_first_out", 8'(bus.resp_out), 8'h4);
    checkOutput("chain_count", 8'(dut.u_fifo.count), 8'd1);
    checkOutput("chain_in1_from_acc", 8'(alu_in1), 8'h4);
    nextCycle();
    checkOutput("chain_second_valid", 8'(bus.resp_valid), 8'd1);
    checkOutput("chain_second_out", 8'(bus.resp_out), 8'hC);
    checkOutput("chain_second_neg", 8'(bus.resp_negative), 8'd1);
    checkOutput("chain_acc", 8'(acc), 8'hC);
    nextCycle();

    $display("[TB] backpressure");
    bus.resp_ready = 1'b0;
    applyStimulus(OP_AND, 4'b0011, 4'b0101, 1'b0);
    applyStimulus(OP_OR, 4'b0011, 4'b0101, 1'b0);
    applyStimulus(OP_NAND, 4'b0011, 4'b0101, 1'b0);
    checkOutput("bp_req_ready", 8'(bus.req_ready), 8'd0);
    checkOutput("bp_valid", 8'(bus.resp_valid), 8'd1);
    checkOutput("bp_first_out", 8'(bus.resp_out), 8'h1);
    nextCycle();
    nextCycle();
    checkOutput("bp_hold_out", 8'(bus.resp_out), 8'h1);
    checkOutput("bp_hold_valid", 8'(bus.resp_valid), 8'd1);
    checkOutput("bp_hold_acc", 8'(acc), 8'h1);
    checkOutput("bp_hold_ready", 8'(bus.req_ready), 8'd0);
    bus.resp_ready = 1'b1;
    nextCycle();
    checkOutput("bp_second_out", 8'(bus.resp_out), 8'h7);
    checkOutput("bp_ready_back", 8'(bus.req_ready), 8'd1);
    nextCycle();
    checkOutput("bp_third_out", 8'(bus.resp_out), 8'hE);
    checkOutput("bp_third_neg", 8'(bus.resp_negative), 8'd1);
    nextCycle();
    checkOutput("bp_drained", 8'(bus.resp_valid), 8'd0);

    $display("[TB] reset mid-operation");
    bus.resp_ready = 1'b0;
    applyStimulus(OP_ADD, 4'd1, 4'd1, 1'b0);
    applyStimulus(OP_ADD, 4'd2, 4'd2, 1'b0);
    applyStimulus(OP_ADD, 4'd3, 4'd3, 1'b0);
    checkOutput("mid_valid_before", 8'(bus.resp_valid), 8'd1);
    checkOutput("mid_full_before", 8'(bus.req_ready), 8'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 8'(bus.resp_valid), 8'd0);
    checkOutput("mid_rst_acc", 8'(acc), 8'd0);
    checkOutput("mid_rst_req_ready", 8'(bus.req_ready), 8'd1);
    checkOutput("mid_rst_alu_op", 8'(alu_op), 8'd0);
    checkOutput("mid_rst_alu_in1", 8'(alu_in1), 8'd0);
    checkOutput("mid_rst_alu_in2", 8'(alu_in2), 8'd0);
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("mid_no_stale", 8'(bus.resp_valid), 8'd0);
    end

    $display("[TB] push/pop at count 1");
    applyStimulus(OP_ADD, 4'b0010, 4'b0010, 1'b0);
    checkOutput("pp_count_one", 8'(dut.u_fifo.count), 8'd1);
    applyStimulus(OP_NOT_A, 4'b1100, 4'b0000, 1'b0);
    checkOutput("pp_count_stays", 8'(dut.u_fifo.count), 8'd1);
    checkOutput("pp_first_out", 8'(bus.resp_out), 8'h4);
    checkOutput("pp_head_op", 8'(alu_op), 8'(OP_NOT_A));
    nextCycle();
    checkOutput("pp_second_out", 8'(bus.resp_out), 8'h3);
    checkOutput("pp_second_valid", 8'(bus.resp_valid), 8'd1);
    checkOutput("pp_count_empty", 8'(dut.u_fifo.count), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
